// File: rtl/qif_pkg.sv
// rtl/qif_pkg.sv - shared defaults and saturation helper for the QIF neuron array
package qif_pkg;

    localparam int V_RESET_DEF = -20;
    localparam int V_PEAK_DEF  = 50;
    localparam int FRAC_DEF    = 3;
    localparam int B_SHIFT_DEF = 2;

    // Clamp a wide signed value into the range of a width-bit two's complement number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/qif_neuron_array_if.sv
// rtl/qif_neuron_array_if.sv - update request / result bundle of the QIF neuron array
interface qif_neuron_array_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CW-1:0]           in_ch;
    logic signed [WIDTH-1:0] in_b;
    logic                    out_valid;
    logic [CW-1:0]           out_ch;
    logic signed [WIDTH-1:0] out_v;
    logic                    out_spike;
    logic                    out_err;

    modport master (
        output in_valid, in_ch, in_b,
        input  in_ready, out_valid, out_ch, out_v, out_spike, out_err
    );

    modport slave (
        input  in_valid, in_ch, in_b,
        output in_ready, out_valid, out_ch, out_v, out_spike, out_err
    );
endinterface

// File: rtl/qif_step.sv
// rtl/qif_step.sv - combinational QIF step: saturating update, spike detect, refractory hold
module qif_step
    import qif_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int FRAC    = FRAC_DEF,
    parameter int B_SHIFT = B_SHIFT_DEF,
    parameter int V_RESET = V_RESET_DEF,
    parameter int V_PEAK  = V_PEAK_DEF,
    parameter int REFRAC  = 2,
    parameter int RW      = 2
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] b,
    input  logic [RW-1:0]           refrac_cnt,
    output logic signed [WIDTH-1:0] v_next,
    output logic                    spike,
    output logic [RW-1:0]           refrac_next
);
    localparam int DW = 3 * WIDTH + 1;
    localparam int SW = DW + 1;
    localparam logic signed [WIDTH-1:0] VR = WIDTH'(V_RESET);
    localparam logic signed [WIDTH-1:0] VP = WIDTH'(V_PEAK);

    logic signed [WIDTH-1:0]   s;
    logic signed [WIDTH-1:0]   bs;
    logic signed [2*WIDTH-1:0] s_ext;
    logic [2*WIDTH-1:0]        q;
    logic signed [DW-1:0]      q_ext;
    logic signed [DW-1:0]      b_ext;
    logic signed [DW-1:0]      d;
    logic signed [SW-1:0]      sum;
    logic signed [63:0]        sat;
    logic signed [WIDTH-1:0]   v_sat;

    assign s     = v >>> FRAC;
    assign bs    = b >>> B_SHIFT;
    assign s_ext = {{WIDTH{s[WIDTH-1]}}, s};
    // The square of the most negative s still fits in 2*WIDTH bits as an unsigned value.
    assign q     = $unsigned(s_ext * s_ext);
    assign q_ext = {{(DW - 2*WIDTH){1'b0}}, q};
    assign b_ext = {{(DW - WIDTH){bs[WIDTH-1]}}, bs};
    assign d     = q_ext * b_ext;
    assign sum   = {d[DW-1], d} + {{(SW - WIDTH){v[WIDTH-1]}}, v};
    assign sat   = sat_signed(64'(sum), WIDTH);
    assign v_sat = sat[WIDTH-1:0];

    always_comb begin
        v_next      = v_sat;
        spike       = 1'b0;
        refrac_next = refrac_cnt;
        if (refrac_cnt != '0) begin
            v_next      = VR;
            refrac_next = refrac_cnt - RW'(1);
        end else if (v_sat >= VP) begin
            v_next      = VR;
            spike       = 1'b1;
            refrac_next = RW'(REFRAC);
        end
    end
endmodule

// File: rtl/qif_neuron_array.sv
// rtl/qif_neuron_array.sv - time-multiplexed QIF neuron array with spike counter and bulk clear
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int FRAC     = FRAC_DEF,
    parameter int B_SHIFT  = B_SHIFT_DEF,
    parameter int V_RESET  = V_RESET_DEF,
    parameter int V_PEAK   = V_PEAK_DEF,
    parameter int REFRAC   = 2,
    parameter int CNT_W    = 16,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    qif_neuron_array_if.slave  bus,
    output logic [CNT_W-1:0]   spike_count
);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [WIDTH-1:0] VR = WIDTH'(V_RESET);

    logic signed [WIDTH-1:0] v_mem  [CHANNELS];
    logic [RW-1:0]           rc_mem [CHANNELS];

    logic                    accept;
    logic                    ch_ok;
    logic [CW-1:0]           idx;
    logic signed [WIDTH-1:0] v_next;
    logic                    spike;
    logic [RW-1:0]           refrac_next;

    // rst_n is an active-high reset despite its name.
    assign bus.in_ready = ~rst_n & ~clear;
    assign accept       = bus.in_valid & bus.in_ready;
    assign ch_ok        = (int'(bus.in_ch) < CHANNELS);
    assign idx          = ch_ok ? bus.in_ch : '0;

    qif_step #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .B_SHIFT (B_SHIFT),
        .V_RESET (V_RESET),
        .V_PEAK  (V_PEAK),
        .REFRAC  (REFRAC),
        .RW      (RW)
    ) u_step (
        .v           (v_mem[idx]),
        .b           (bus.in_b),
        .refrac_cnt  (rc_mem[idx]),
        .v_next      (v_next),
        .spike       (spike),
        .refrac_next (refrac_next)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                v_mem[i]  <= VR;
                rc_mem[i] <= '0;
            end
            spike_count   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_spike <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_v     <= VR;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                v_mem[i]  <= VR;
                rc_mem[i] <= '0;
            end
            spike_count   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_spike <= 1'b0;
            bus.out_err   <= 1'b0;
        end else begin
            bus.out_valid <= accept;
            bus.out_spike <= 1'b0;
            bus.out_err   <= 1'b0;
            if (accept) begin
                bus.out_ch <= bus.in_ch;
                if (ch_ok) begin
                    v_mem[idx]    <= v_next;
                    rc_mem[idx]   <= refrac_next;
                    bus.out_v     <= v_next;
                    bus.out_spike <= spike;
                    if (spike && spike_count != '1)
                        spike_count <= spike_count + CNT_W'(1);
                end else begin
                    bus.out_v   <= VR;
                    bus.out_err <= 1'b1;
                end
            end
        end
    end
endmodule
